run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl_pkg.sv | 16 +
 rtl/btn_debounce.sv | 61 ++++++
 rtl/run_ctrl.sv | 123 ++++++++++++
 tb/tb_run_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared state encodings and default timing constants for the run controller.
// No logic here; imported by run_ctrl and btn_debounce.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } run_state_e;

    localparam int unsigned DEF_FAST_DIV   = 6;
    localparam int unsigned DEF_SLOW_DIV   = 3000000;
    localparam int unsigned DEF_DEB_CYCLES = 20000;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop sync, stability counter, one-cycle pulse on accepted press.
// Latency: pulse DEB_CYCLES+3 cycles after a clean rise; no backpressure, pulse is not held.
module btn_debounce
    import run_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk_in,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_pulse
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] stab_cnt_q, stab_cnt_d;
    logic          level_q, level_d;
    logic          level_dly_q, level_dly_d;
    logic          pulse_q, pulse_d;

    always_comb begin
        sync1_d     = btn_raw;
        sync2_d     = sync1_q;
        level_d     = level_q;
        stab_cnt_d  = '0;
        // Any return to the accepted level restarts the stability window.
        if (sync2_q != level_q) begin
            if (stab_cnt_q == LAST) begin
                level_d = sync2_q;
            end else begin
                stab_cnt_d = stab_cnt_q + 1'b1;
            end
        end
        level_dly_d = level_q;
        pulse_d     = level_q & ~level_dly_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            stab_cnt_q  <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            stab_cnt_q  <= stab_cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            pulse_q     <= pulse_d;
        end
    end

    assign btn_pulse = pulse_q;

endmodule

// File: rtl/run_ctrl.sv
// CPU clock-enable controller: free-run prescaler, single-step and halt/resume FSM.
// Latency: run ticks every DIV cycles, step enable one cycle after debounced press; no backpressure.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned FAST_DIV   = DEF_FAST_DIV,
    parameter int unsigned SLOW_DIV   = DEF_SLOW_DIV,
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        run_sw,
    input  logic        fast_sw,
    input  logic        step_btn,
    input  logic        resume_btn,
    input  logic        halt_req,
    output logic        cpu_en,
    output logic        halted,
    output logic [1:0]  state,
    output logic [31:0] tick_cnt
);

    logic step_pulse;
    logic resume_pulse;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
        .clk_in    (clk_in),
        .rst       (rst),
        .btn_raw   (step_btn),
        .btn_pulse (step_pulse)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_resume_deb (
        .clk_in    (clk_in),
        .rst       (rst),
        .btn_raw   (resume_btn),
        .btn_pulse (resume_pulse)
    );

    run_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] tick_cnt_q, tick_cnt_d;
    logic        fast_q, fast_d;
    logic        halt_q, halt_d;
    logic        step_pend_q, step_pend_d;

    logic [31:0] div;
    logic        fast_chg;
    logic        halt_edge;
    logic        tick;

    always_comb begin
        div       = fast_sw ? 32'(FAST_DIV) : 32'(SLOW_DIV);
        fast_chg  = fast_sw != fast_q;
        halt_edge = halt_req && !halt_q && (state_q == ST_RUN || state_q == ST_STEP);
        tick      = (state_q == ST_RUN) && !fast_chg && (cnt_q == div - 32'd1);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        cpu_en      = 1'b0;
        step_pend_d = (state_q == ST_STEP) && step_pulse;
        fast_d      = fast_sw;
        halt_d      = halt_req;
        unique case (state_q)
            ST_IDLE: state_d = run_sw ? ST_RUN : ST_STEP;
            ST_RUN: begin
                if (halt_edge) begin
                    state_d = ST_HALT;
                end else if (!run_sw) begin
                    state_d = ST_STEP;
                end else begin
                    cpu_en = tick;
                    cnt_d  = (fast_chg || tick) ? 32'd0 : cnt_q + 32'd1;
                end
            end
            ST_STEP: begin
                if (halt_edge) begin
                    state_d = ST_HALT;
                end else if (run_sw) begin
                    state_d = ST_RUN;
                end else begin
                    cpu_en = step_pend_q;
                end
            end
            ST_HALT: begin
                if (resume_pulse) begin
                    state_d = run_sw ? ST_RUN : ST_STEP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Reset must suppress the enable in the very cycle it is sampled.
        if (rst) begin
            cpu_en = 1'b0;
        end
        tick_cnt_d = tick_cnt_q + {31'b0, cpu_en};
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tick_cnt_q  <= '0;
            fast_q      <= 1'b0;
            halt_q      <= 1'b0;
            step_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            fast_q      <= fast_d;
            halt_q      <= halt_d;
            step_pend_q <= step_pend_d;
        end
    end

    assign halted   = (state_q == ST_HALT);
    assign state    = state_q;
    assign tick_cnt = tick_cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed scenarios plus random stimulus,
// every cycle compared against a timestamp/history based reference model.
module tb_run_ctrl;

    localparam int FAST = 6;
    localparam int SLOW = 20;
    localparam int DEB  = 4;
    localparam int MAXC = 8192;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic        run_sw = 1'b1;
    logic        fast_sw = 1'b1;
    logic        step_btn = 1'b0;
    logic        resume_btn = 1'b0;
    logic        halt_req = 1'b0;
    logic        cpu_en;
    logic        halted;
    logic [1:0]  state;
    logic [31:0] tick_cnt;

    run_ctrl #(.FAST_DIV(FAST), .SLOW_DIV(SLOW), .DEB_CYCLES(DEB)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .run_sw     (run_sw),
        .fast_sw    (fast_sw),
        .step_btn   (step_btn),
        .resume_btn (resume_btn),
        .halt_req   (halt_req),
        .cpu_en     (cpu_en),
        .halted     (halted),
        .state      (state),
        .tick_cnt   (tick_cnt)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state
    int          m_state = 0;
    int          run_start = 0;
    bit          m_prev_fast = 1'b0;
    bit          m_prev_halt = 1'b0;
    bit          m_step_due = 1'b0;
    bit          lvl_step = 1'b0;
    bit          lvl_res = 1'b0;
    logic [31:0] mtick = '0;
    int          valid_from = 0;
    bit          step_hist [MAXC];
    bit          res_hist [MAXC];

    bit saw_pulse = 1'b0;
    int npulses = 0;
    int last_pulse_cyc = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // A press is accepted when the raw input held the opposite level for DEB
    // whole cycles; the pulse shows up 3 cycles after that window ends.
    task automatic deb_eval(input bit sel, output bit p);
        bit lvl, v, flip;
        int idx;
        lvl  = sel ? lvl_res : lvl_step;
        flip = 1'b1;
        for (int i = 0; i < DEB; i++) begin
            idx = cyc - 4 - i;
            v = (idx < valid_from) ? 1'b0 : (sel ? res_hist[idx] : step_hist[idx]);
            if (v == lvl) flip = 1'b0;
        end
        if (flip) lvl = ~lvl;
        p = flip && lvl;
        if (sel) lvl_res = lvl; else lvl_step = lvl;
    endtask

    task automatic cyc_run();
        bit sp, rp, hedge, fchg, en;
        int div;
        #1;
        step_hist[cyc] = step_btn;
        res_hist[cyc]  = resume_btn;
        deb_eval(1'b0, sp);
        deb_eval(1'b1, rp);
        div   = fast_sw ? FAST : SLOW;
        hedge = halt_req && !m_prev_halt && (m_state == 1 || m_state == 2);
        fchg  = fast_sw != m_prev_fast;
        en    = 1'b0;
        if (!rst) begin
            if (m_state == 1)
                en = !hedge && run_sw && !fchg && (((cyc - run_start) % div) == div - 1);
            else if (m_state == 2)
                en = !hedge && !run_sw && m_step_due;
        end
        chk("state", 32'(state), 32'(m_state));
        chk("halted", 32'(halted), 32'(m_state == 3));
        chk("cpu_en", 32'(cpu_en), 32'(en));
        chk("tick_cnt", tick_cnt, mtick);
        saw_pulse = cpu_en;
        if (cpu_en) begin
            npulses++;
            last_pulse_cyc = cyc;
        end
        mtick = mtick + 32'(en);
        if (rst) begin
            m_state = 0; mtick = '0; m_prev_fast = 1'b0; m_prev_halt = 1'b0;
            m_step_due = 1'b0; valid_from = cyc + 1; lvl_step = 1'b0; lvl_res = 1'b0;
        end else begin
            m_step_due = (m_state == 2) && sp;
            case (m_state)
                0: begin m_state = run_sw ? 1 : 2; run_start = cyc + 1; end
                1: if (hedge) m_state = 3;
                   else if (!run_sw) m_state = 2;
                   else if (fchg) run_start = cyc + 1;
                2: if (hedge) m_state = 3;
                   else if (run_sw) begin m_state = 1; run_start = cyc + 1; end
                default: if (rp) begin m_state = run_sw ? 1 : 2; run_start = cyc + 1; end
            endcase
            m_prev_fast = fast_sw;
            m_prev_halt = halt_req;
        end
        cyc++;
        @(posedge clk_in);
        #1;
    endtask

    task automatic run_n(input int k);
        for (int i = 0; i < k; i++) cyc_run();
    endtask

    task automatic wait_pulse(input int budget, input string tag, output int pc);
        bit seen;
        seen = 1'b0;
        pc = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            cyc_run();
            if (saw_pulse) begin
                seen = 1'b1;
                pc = last_pulse_cyc;
            end
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int p, prev, t0, n0, sleft, rleft;
        @(posedge clk_in);
        #1;

        // Reset, then fast free-run
        run_n(3);
        rst = 1'b0;
        t0 = cyc;
        wait_pulse(20, "first", p);
        chk("first_gap", 32'(p - t0), 32'd6);
        for (int k = 0; k < 4; k++) begin
            prev = p;
            wait_pulse(20, "fast", p);
            chk("gap_fast", 32'(p - prev), 32'd6);
        end
        chk("tick_cnt5", tick_cnt, 32'd5);

        // Speed change clears the prescaler
        fast_sw = 1'b0;
        t0 = cyc;
        wait_pulse(40, "slow", p);
        chk("slow_first", 32'(p - t0), 32'd20);
        for (int k = 0; k < 2; k++) begin
            prev = p;
            wait_pulse(40, "slow", p);
            chk("gap_slow", 32'(p - prev), 32'd20);
        end

        // Single step: one long press, then a short glitch
        run_sw = 1'b0;
        run_n(4);
        n0 = npulses;
        step_btn = 1'b1;
        t0 = cyc;
        run_n(10);
        step_btn = 1'b0;
        run_n(6);
        step_btn = 1'b1;
        run_n(2);
        step_btn = 1'b0;
        run_n(12);
        chk("step_cnt", 32'(npulses - n0), 32'd1);
        chk("step_lat", 32'(last_pulse_cyc - t0), 32'd8);

        // Halt edge coinciding with a tick
        run_sw = 1'b1;
        fast_sw = 1'b1;
        run_n(1);
        for (int i = 0; i < 20; i++) begin
            if (m_state == 1 && ((cyc - run_start) % FAST) == FAST - 1) break;
            cyc_run();
        end
        halt_req = 1'b1;
        cyc_run();
        chk("halt_noen", 32'(saw_pulse), 32'd0);
        chk("halt_state", 32'(state), 32'd3);
        chk("halt_flag", 32'(halted), 32'd1);
        n0 = npulses;
        step_btn = 1'b1;
        run_n(8);
        step_btn = 1'b0;
        run_n(6);
        chk("halt_step_ign", 32'(npulses - n0), 32'd0);
        resume_btn = 1'b1;
        run_n(10);
        resume_btn = 1'b0;
        chk("resume_state", 32'(state), 32'd1);
        wait_pulse(20, "res1", prev);
        wait_pulse(20, "res2", p);
        chk("res_gap", 32'(p - prev), 32'd6);

        // Counter wrap, then reset mid-run
        force dut.tick_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.tick_cnt_q;
        mtick = 32'hFFFF_FFFF;
        wait_pulse(20, "wrapa", p);
        chk("wrap0", tick_cnt, 32'h0);
        wait_pulse(20, "wrapb", p);
        chk("wrap1", tick_cnt, 32'h1);
        halt_req = 1'b0;
        rst = 1'b1;
        run_n(1);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_en", 32'(cpu_en), 32'd0);
        chk("rst_tick", tick_cnt, 32'd0);

        // Button held through reset release
        run_sw = 1'b0;
        step_btn = 1'b1;
        run_n(2);
        rst = 1'b0;
        t0 = cyc;
        wait_pulse(15, "rst_hold", p);
        chk("rst_hold_lat", 32'(p - t0), 32'd8);
        step_btn = 1'b0;
        run_n(6);

        // Random phase
        sleft = 0;
        rleft = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(39) == 0) run_sw = ~run_sw;
            if ($urandom_range(59) == 0) fast_sw = ~fast_sw;
            if ($urandom_range(49) == 0) halt_req = ~halt_req;
            rst = ($urandom_range(299) == 0);
            if (sleft == 0) begin
                step_btn = ~step_btn;
                sleft = int'($urandom_range(12, 1));
            end
            sleft--;
            if (rleft == 0) begin
                resume_btn = ~resume_btn;
                rleft = int'($urandom_range(14, 1));
            end
            rleft--;
            cyc_run();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
